// File: rtl/sha256_compress_if.sv
// Block/digest bus between the message-block builder and the SHA-256 compressor.
// The builder drives the block side; the compressor returns the digest side.
interface sha256_compress_if #(
   parameter int NW = 32,
   parameter int NI = 64
);
   logic [16*NW-1:0] Data;
   logic [NI-1:0]    Index;
   logic             Valid;
   logic             Function;
   logic [8*NW-1:0]  Hash;
   logic [NI-1:0]    Hash_Index;
   logic             Busy;
   logic             Ready;

   modport master (
      output Data, Index, Valid, Function,
      input  Hash, Hash_Index, Busy, Ready
   );

   modport slave (
      input  Data, Index, Valid, Function,
      output Hash, Hash_Index, Busy, Ready
   );
endinterface

// File: rtl/sha256_compress.sv
// SHA-256 compression core: one 512-bit block per handshake, one round per cycle,
// on-the-fly message schedule and a chaining value that persists across blocks.
module sha256_compress #(
   parameter int NW = 32,
   parameter int NR = 64,
   parameter int NI = 64
) (
   input logic             clk,
   input logic             rst,
   sha256_compress_if.slave bus
);

   localparam int TW = $clog2(NR);

   localparam logic [NW-1:0] IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [NW-1:0] K_ROM [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_t;

   function automatic logic [NW-1:0] rotr(input logic [NW-1:0] x, input int n);
      return (x >> n) | (x << (NW - n));
   endfunction

   function automatic logic [NW-1:0] bsig0(input logic [NW-1:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [NW-1:0] bsig1(input logic [NW-1:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [NW-1:0] ssig0(input logic [NW-1:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [NW-1:0] ssig1(input logic [NW-1:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   state_t        state, state_next;
   logic          accept, load_en, round_en, final_en;
   logic [TW-1:0] t;
   logic          last_round;

   logic [NW-1:0] w [16];
   logic [NW-1:0] v [8];
   logic [NW-1:0] h [8];
   logic [NI-1:0] idx_q;
   logic          fn_q;
   logic [NI-1:0] hash_index;
   logic          ready;

   logic [NW-1:0] t1, t2, w_new;

   assign last_round = (t == TW'(NR - 1));

   // NOTE: sequential state uses <= so every register samples the pre-edge
   // values; blocking writes here would make results depend on statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (bus.Valid) state_next = LOAD;
         LOAD:    state_next = ROUND;
         ROUND:   if (last_round) state_next = FINAL;
         FINAL:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      accept   = 1'b0;
      load_en  = 1'b0;
      round_en = 1'b0;
      final_en = 1'b0;
      unique case (state)
         IDLE:    accept   = bus.Valid;
         LOAD:    load_en  = 1'b1;
         ROUND:   round_en = 1'b1;
         FINAL:   final_en = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      t1    = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_ROM[t] + w[0];
      t2    = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
   end

   // NOTE: the schedule window and working set are reset like any other
   // register so a block abandoned by reset leaves no residue behind.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) w[i] <= '0;
         for (int i = 0; i < 8; i++) begin
            v[i] <= '0;
            h[i] <= '0;
         end
         t          <= '0;
         idx_q      <= '0;
         fn_q       <= 1'b0;
         hash_index <= '0;
         ready      <= 1'b0;
      end else begin
         ready <= final_en;

         if (accept) begin
            for (int i = 0; i < 16; i++) w[i] <= bus.Data[i*NW +: NW];
            idx_q <= bus.Index;
            fn_q  <= bus.Function;
         end

         if (load_en) begin
            t <= '0;
            for (int i = 0; i < 8; i++) begin
               if (!fn_q) begin
                  h[i] <= IV[i];
                  v[i] <= IV[i];
               end else begin
                  v[i] <= h[i];
               end
            end
         end

         if (round_en) begin
            v[0] <= t1 + t2;
            v[1] <= v[0];
            v[2] <= v[1];
            v[3] <= v[2];
            v[4] <= v[3] + t1;
            v[5] <= v[4];
            v[6] <= v[5];
            v[7] <= v[6];
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_new;
            // Hold at the last index rather than wrapping; LOAD rewinds it.
            if (!last_round) t <= t + TW'(1);
         end

         if (final_en) begin
            for (int i = 0; i < 8; i++) h[i] <= h[i] + v[i];
            hash_index <= idx_q;
         end
      end
   end

   always_comb begin
      bus.Hash = '0;
      for (int i = 0; i < 8; i++) bus.Hash[(7-i)*NW +: NW] = h[i];
   end

   assign bus.Hash_Index = hash_index;
   assign bus.Ready      = ready;
   assign bus.Busy       = (state != IDLE);

endmodule
